// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes, ALUOp and ALUControl codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_pkg;

    // FSM states; encodings are visible on the debug port and must stay fixed
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALUOp: what the main FSM asks of the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // funct3 values the ALU supports for R/I-type (add/sub, slt, or, and)
    function automatic logic funct3_supported(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Maps ALUOp plus instruction fields to the 3-bit ALUControl code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
module alu_decoder
    import mc_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic        op_b5,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    output logic [2:0]  alu_control
);

    // Decode the ALU operation; sub only for R-type (op[5]) with funct7[5] set
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V control FSM: sequences shared ALU, regfile and unified memory per instruction.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles; outputs combinational from state and inputs.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low, one extra cycle per low cycle.
module mc_controller
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  imm_src,
    output logic [2:0]  alu_control,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t  state_q;
    state_t  state_nxt;
    alu_op_t alu_op;
    logic    pc_write_c;
    logic    ir_write_c;

    // State register: the only storage in the controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state and per-state control decode
    always_comb begin
        state_nxt  = S_FETCH;
        pc_write_c = 1'b0;
        ir_write_c = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_nxt  = S_DECODE;
                end else begin
                    state_nxt  = S_FETCH;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R: begin
                        if (funct3_supported(funct3)) state_nxt = S_EXECR;
                        else                          illegal   = 1'b1;
                    end
                    OP_I: begin
                        if (funct3_supported(funct3)) state_nxt = S_EXECI;
                        else                          illegal   = 1'b1;
                    end
                    OP_JAL: state_nxt = S_JAL;
                    OP_BEQ: begin
                        if (funct3 == 3'b000) state_nxt = S_BEQ;
                        else                  illegal   = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src   = 1'b1;
                state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays high for the whole access, including wait cycles
                adr_src   = 1'b1;
                mem_write = 1'b1;
                state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
                state_nxt = S_ALUWB;
            end
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_write_c = 1'b1;
                state_nxt  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b00;
                alu_op     = ALUOP_SUB;
                pc_write_c = zero;
                state_nxt  = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // FETCH enables depend on mem_ready combinationally; mask them while reset is held
    assign pc_write = pc_write_c & rst_n;
    assign ir_write = ir_write_c & rst_n;
    assign state    = state_q;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .op_b5       (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RISC-V core. It sequences one shared ALU, register file and unified instruction/data memory across several cycles per instruction. It produces mux selects, write enables and the 3-bit `ALUControl` code consumed by the ALU, and uses the ALU `Zero` flag for `beq`. Memory accesses use a ready handshake so the core can stall on slow memory.

## Interface
Parameters: none. Opcode, `ALUControl` and state encodings are fixed in `mc_pkg`.

- `clk`  in  1  core clock; all state changes on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `op`  in  7  instruction opcode, taken from the instruction register
- `funct3`  in  3  instruction bits [14:12]
- `funct7b5`  in  1  instruction bit 30
- `zero`  in  1  ALU `Zero` flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write`  out  1  memory write strobe
- `ir_write`  out  1  instruction/OldPC register enable
- `reg_write`  out  1  register file write enable
- `result_src`  out  2  00 = ALUOut, 01 = Data, 10 = ALU result
- `alu_src_a`  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
- `alu_src_b`  out  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4
- `imm_src`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `alu_control`  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- `illegal`  out  1  one-cycle pulse when an unsupported instruction is decoded
- `state`  out  4  current state, for debug

## Operation
- State register is the only storage; all outputs are combinational from `state`, `op`, `funct3`, `funct7b5`, `zero` and `mem_ready`.
- Any output not listed for a state is 0.
- States, with encoding, asserted outputs and next state:
  - FETCH (0): `alu_src_b`=10, `result_src`=10, ALUOp 00. `ir_write` and `pc_write` assert only when `mem_ready`=1. Next state is DECODE when `mem_ready`=1, otherwise FETCH.
  - DECODE (1): `alu_src_a`=01, `alu_src_b`=01, ALUOp 00. Next state is chosen by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - otherwise → FETCH with `illegal`=1
  - R/I-type with `funct3` ∉ {000, 010, 110, 111}, or `beq` with `funct3`≠000, is also illegal and returns to FETCH.
  - MEMADR (2): `alu_src_a`=10, `alu_src_b`=01, ALUOp 00. Next state is MEMREAD if `op`[5]=0, otherwise MEMWRITE.
  - MEMREAD (3): `adr_src`=1. Waits for `mem_ready`, then goes to MEMWB.
  - MEMWB (4): `result_src`=01, `reg_write`=1. Next state is FETCH.
  - MEMWRITE (5): `adr_src`=1, `mem_write`=1. `mem_write` is held high through wait cycles. Waits for `mem_ready`, then goes to FETCH.
  - EXECR (6): `alu_src_a`=10, `alu_src_b`=00, ALUOp 10. Next state is ALUWB.
  - EXECI (7): `alu_src_a`=10, `alu_src_b`=01, ALUOp 10. Next state is ALUWB.
  - JAL (8): `alu_src_a`=01, `alu_src_b`=10, `result_src`=00, `pc_write`=1. Next state is ALUWB.
  - ALUWB (9): `result_src`=00, `reg_write`=1. Next state is FETCH.
  - BEQ (10): `alu_src_a`=10, `alu_src_b`=00, ALUOp 01, `pc_write`=`zero`. Next state is FETCH.
- ALU decoder, mapping ALUOp to `alu_control`:
  - ALUOp 00 → add; ALUOp 01 → sub.
  - ALUOp 10 with `funct3`=000 → sub if `op`[5] & `funct7b5`, else add.
  - ALUOp 10 with `funct3`=010 → slt; 110 → or; 111 → and.
  - ALUOp 10 with any other `funct3` → add. This case is unreachable because DECODE filters it.
- `imm_src` is decoded from `op` in every state. Unknown `op` gives 00.
- Encodings 11–15 of the state register are unreachable; if entered, next state is FETCH.

## Timing
- Reset: asserting `rst_n`=0 forces FETCH immediately, mid-instruction included.
  - During and after reset the outputs are: `pc_write`=0, `ir_write`=0, `mem_write`=0, `reg_write`=0, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `result_src`=10, `alu_control`=000, `illegal`=0, `state`=0.
  - `imm_src` follows `op`.
- Cycles per instruction with `mem_ready` held at 1:
  - lw: 5
  - sw, R-type, I-type, jal: 4
  - beq: 3
  - illegal: 2
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. No other state samples `mem_ready`.
- `pc_write` and `ir_write` in FETCH rise in the same cycle as `mem_ready` (combinational path). The PC therefore advances exactly once per fetch.
- `zero` is sampled only in BEQ. `illegal` is high only in the DECODE cycle that detects the fault.

## Structure
- `mc_pkg` holds:
  - `state_t` enum with the encodings above
  - opcode constants: `OP_LW`, `OP_SW`, `OP_R`, `OP_I`, `OP_JAL`, `OP_BEQ`
  - `alu_op_t` (00/01/10)
  - `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`
- One sub-module, `alu_decoder`, combinational: inputs ALUOp, `op`[5], `funct3`, `funct7b5`; output `alu_control`.
- FSM next-state logic and output decode stay in `mc_controller`.

## Test plan
- Reset with `rst_n`=0 in MEMWRITE, `mem_ready`=0 → `state`=0 and `mem_write`=0 immediately; all outputs equal the listed reset values.
- `op`=0000011, `mem_ready`=1 → states 0,1,2,3,4,0; `reg_write`=1 only in state 4 with `result_src`=01; 5 cycles total.
- `op`=0100011, `mem_ready` low for 3 cycles in MEMWRITE → `mem_write`=1 for 4 consecutive cycles, then FETCH.
- R-type `op`=0110011, `funct3`=000, `funct7b5`=1 → `alu_control`=001 in EXECR. Same with `funct7b5`=0 → 000. `funct3`=010 → 101.
- I-type `op`=0010011, `funct3`=000, `funct7b5`=1 → `alu_control`=000 (addi, not sub).
- `op`=1100011 with `zero`=1 → `pc_write`=1 in BEQ. With `zero`=0 → `pc_write`=0. `op`=1110011 → `illegal` pulses for one cycle and the next state is FETCH.
